// File: rtl/dump_pkg.sv
// Shared definitions for the end-of-program state dump unit: stream tags,
// FSM state encoding, end-marker payload and default dump geometry.
package dump_pkg;

    // Stream word tags carried on out_tag.
    localparam logic [1:0] TAG_REG = 2'b00;
    localparam logic [1:0] TAG_MEM = 2'b01;
    localparam logic [1:0] TAG_END = 2'b11;

    // Payload of the end-of-stream marker.
    localparam logic [31:0] END_INDEX = 32'h0000_0000;
    localparam logic [31:0] END_DATA  = 32'hFFFF_FFFF;

    // Default dump geometry: full register file and a 12 KiB data window.
    localparam int DEFAULT_NUM_REGS  = 32;
    localparam int DEFAULT_MEM_BYTES = 32'h3000;

    // Dump sequencer states, visited strictly in this order.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REGS = 3'd1,
        ST_MEM  = 3'd2,
        ST_END  = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_state_dumper.sv
// End-of-program state dump unit. On syscall it freezes the CPU via halt,
// then streams every register and every data-memory word of the dump window,
// followed by an end marker, on a valid/ready interface in MARS dump order.
module cpu_state_dumper
    import dump_pkg::*;
#(
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall,
    output logic        halt,
    output logic [4:0]  reg_rd_addr,
    input  logic [31:0] reg_rd_data,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_tag,
    output logic [31:0] out_index,
    output logic [31:0] out_data,
    output logic        done
);

    // Final pointer values of each phase.
    localparam logic [31:0] LAST_REG = 32'(NUM_REGS - 1);
    localparam logic [31:0] LAST_MEM = 32'(MEM_BYTES - 4);

    dump_state_e state_r;
    logic [31:0] idx_r;

    // The output register may take a new item when empty or being drained.
    logic slot_free_s;
    // The end marker is already sitting in the output register.
    logic end_loaded_s;

    assign slot_free_s  = !out_valid || out_ready;
    assign end_loaded_s = out_valid && (out_tag == TAG_END);

    // Read addresses follow state and pointer directly so the read data is
    // available in the same cycle the item is captured.
    always_comb begin
        reg_rd_addr = 5'd0;
        mem_rd_addr = 32'd0;
        case (state_r)
            ST_REGS: reg_rd_addr = idx_r[4:0];
            ST_MEM:  mem_rd_addr = word_align(idx_r);
            default: begin
                reg_rd_addr = 5'd0;
                mem_rd_addr = 32'd0;
            end
        endcase
    end

    // Dump sequencer: state, pointer and the registered stream outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 32'd0;
            halt      <= 1'b0;
            out_valid <= 1'b0;
            out_tag   <= 2'b00;
            out_index <= 32'd0;
            out_data  <= 32'd0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    halt <= 1'b0;
                    if (syscall) begin
                        // Reads start next cycle, by which point the CPU
                        // is already frozen.
                        state_r <= ST_REGS;
                        idx_r   <= 32'd0;
                        halt    <= 1'b1;
                    end
                end

                ST_REGS: begin
                    if (slot_free_s) begin
                        out_valid <= 1'b1;
                        out_tag   <= TAG_REG;
                        out_index <= idx_r;
                        out_data  <= reg_rd_data;
                        if (idx_r == LAST_REG) begin
                            state_r <= ST_MEM;
                            idx_r   <= 32'd0;
                        end else begin
                            idx_r <= idx_r + 32'd1;
                        end
                    end
                end

                ST_MEM: begin
                    if (slot_free_s) begin
                        out_valid <= 1'b1;
                        out_tag   <= TAG_MEM;
                        out_index <= word_align(idx_r);
                        out_data  <= mem_rd_data;
                        if (idx_r == LAST_MEM) begin
                            state_r <= ST_END;
                            idx_r   <= 32'd0;
                        end else begin
                            idx_r <= idx_r + 32'd4;
                        end
                    end
                end

                ST_END: begin
                    if (end_loaded_s) begin
                        // Marker is pending: finish once it is accepted.
                        if (out_ready) begin
                            state_r   <= ST_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else if (slot_free_s) begin
                        out_valid <= 1'b1;
                        out_tag   <= TAG_END;
                        out_index <= END_INDEX;
                        out_data  <= END_DATA;
                    end
                end

                ST_DONE: begin
                    // Terminal until reset; syscall has no effect here.
                    halt      <= 1'b1;
                    done      <= 1'b1;
                    out_valid <= 1'b0;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= 32'd0;
                    halt      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench for cpu_state_dumper: expected beats are queued when a
// dump is triggered, observed beats are collected by a monitor, and each test
// task compares them inline.
module tb_cpu_state_dumper;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] index;
        logic [31:0] data;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        syscall;
    logic        halt;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_tag;
    logic [31:0] out_index;
    logic [31:0] out_data;
    logic        done;

    int checks   = 0;
    int failures = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    stall_viol = 0;
    int    rd_viol    = 0;

    logic [31:0] rf_model  [0:31];
    logic [31:0] mem_model [0:3071];

    cpu_state_dumper dut (
        .clock       (clock),
        .reset       (reset),
        .syscall     (syscall),
        .halt        (halt),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tag     (out_tag),
        .out_index   (out_index),
        .out_data    (out_data),
        .done        (done)
    );

    always #5 clock = ~clock;

    assign reg_rd_data = rf_model[reg_rd_addr];
    assign mem_rd_data = (mem_rd_addr < 32'h3000) ? mem_model[mem_rd_addr[13:2]] : 32'hDEAD_BEEF;

    // Monitor: records accepted beats, stall stability and early reads.
    initial begin
        logic        prev_stall;
        logic        prev_reset;
        beat_t       prev_beat;
        prev_stall = 1'b0;
        prev_reset = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clock);
            if (prev_stall && prev_reset && reset === 1'b1) begin
                if (out_valid !== 1'b1 || out_tag !== prev_beat.tag ||
                    out_index !== prev_beat.index || out_data !== prev_beat.data)
                    stall_viol++;
            end
            if (halt !== 1'b1 && (reg_rd_addr !== 5'd0 || mem_rd_addr !== 32'd0))
                rd_viol++;
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_reset = reset;
            prev_beat  = {out_tag, out_index, out_data};
            if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
                obs_q.push_back({out_tag, out_index, out_data});
        end
    end

    task automatic push_expected();
        exp_q.delete();
        obs_q.delete();
        for (int r = 0; r < 32; r++)
            exp_q.push_back({2'b00, 32'(r), 32'(r) * 32'h11});
        for (int w = 0; w < 3072; w++)
            exp_q.push_back({2'b01, 32'(w * 4), 32'hA000_0000 + 32'(w)});
        exp_q.push_back({2'b11, 32'h0, 32'hFFFF_FFFF});
    endtask

    task automatic do_reset();
        syscall = 1'b0;
        reset   = 1'b0;
        @(posedge clock); #1;
        reset   = 1'b1;
    endtask

    task automatic trigger();
        syscall = 1'b1;
        @(posedge clock); #1;
        syscall = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        while (cycles < budget) begin
            out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            @(posedge clock); #1;
            cycles++;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        syscall   = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        checks++;
        if ({halt, out_valid, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: halt/valid/done=%b required 000", {halt, out_valid, done});
        end
        checks++;
        if ({out_tag, out_index, out_data} !== 66'd0) begin
            failures++;
            $display("FAIL reset_data: tag=%h index=%h data=%h required all 0", out_tag, out_index, out_data);
        end
        checks++;
        if (reg_rd_addr !== 5'd0 || mem_rd_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_addr: reg=%h mem=%h required 0", reg_rd_addr, mem_rd_addr);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_beats: %0d beats during reset, required 0", obs_q.size());
        end
        syscall = 1'b0;
        reset   = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: halt=%b required 0", halt);
        end
    endtask

    task automatic test_full_dump();
        int cycles;
        bit to;
        int mm;
        int first;
        do_reset();
        push_expected();
        out_ready = 1'b1;
        trigger();
        checks++;
        if (halt !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL trig_latency: halt=%b valid=%b required halt=1 valid=0", halt, out_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b1 || {out_tag, out_index, out_data} !== 66'd0) begin
            failures++;
            $display("FAIL first_word: valid=%b beat=%h required valid=1 beat=0", out_valid, {out_tag, out_index, out_data});
        end
        wait_done(4000, 1'b0, cycles, to);
        checks++;
        if (to || cycles + 1 != 3106) begin
            failures++;
            $display("FAIL done_latency: done after edge N+%0d (timeout=%0d) required N+3106", cycles + 1, to);
        end
        checks++;
        if (obs_q.size() != 3105) begin
            failures++;
            $display("FAIL beat_count: %0d required 3105", obs_q.size());
        end
        if (obs_q.size() == 3105) begin
            checks++;
            if (obs_q[0] !== {2'b00, 32'd0, 32'd0}) begin
                failures++;
                $display("FAIL beat1: got %h required %h", obs_q[0], {2'b00, 32'd0, 32'd0});
            end
            checks++;
            if (obs_q[28] !== {2'b00, 32'd28, 32'h1DC}) begin
                failures++;
                $display("FAIL beat29: got %h required %h", obs_q[28], {2'b00, 32'd28, 32'h1DC});
            end
            checks++;
            if (obs_q[32] !== {2'b01, 32'h0, 32'hA000_0000}) begin
                failures++;
                $display("FAIL beat33: got %h required %h", obs_q[32], {2'b01, 32'h0, 32'hA000_0000});
            end
            checks++;
            if (obs_q[3103] !== {2'b01, 32'h2FFC, 32'hA000_0BFF}) begin
                failures++;
                $display("FAIL beat3104: got %h required %h", obs_q[3103], {2'b01, 32'h2FFC, 32'hA000_0BFF});
            end
            checks++;
            if (obs_q[3104] !== {2'b11, 32'h0, 32'hFFFF_FFFF}) begin
                failures++;
                $display("FAIL beat3105: got %h required %h", obs_q[3104], {2'b11, 32'h0, 32'hFFFF_FFFF});
            end
        end
        mm = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                mm++;
                if (first < 0) first = i;
            end
        checks++;
        if (mm != 0 || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL full_stream: %0d bad beats (first %0d), got %0d beats required %0d", mm, first, obs_q.size(), exp_q.size());
        end
        checks++;
        if ({halt, done, out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL full_final: halt/done/valid=%b required 110", {halt, done, out_valid});
        end
    endtask

    task automatic test_backpressure();
        int cycles;
        bit to;
        int mm;
        int first;
        int viol0;
        do_reset();
        push_expected();
        viol0 = stall_viol;
        trigger();
        wait_done(20000, 1'b1, cycles, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL bp_timeout: done not seen in %0d cycles, required done=1", cycles);
        end
        mm = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                mm++;
                if (first < 0) first = i;
            end
        checks++;
        if (mm != 0 || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_stream: %0d bad beats (first %0d), got %0d beats required %0d", mm, first, obs_q.size(), exp_q.size());
        end
        checks++;
        if (stall_viol != viol0) begin
            failures++;
            $display("FAIL bp_stable: %0d unstable stall cycles required 0", stall_viol - viol0);
        end
    endtask

    task automatic test_retrigger();
        int cycles;
        bit to;
        int mm;
        do_reset();
        push_expected();
        out_ready = 1'b1;
        trigger();
        repeat (5) begin
            @(posedge clock); #1;
        end
        trigger();
        wait_done(4000, 1'b0, cycles, to);
        trigger();
        repeat (10) begin
            @(posedge clock); #1;
        end
        mm = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mm++;
        checks++;
        if (to || mm != 0 || obs_q.size() != 3105) begin
            failures++;
            $display("FAIL retrig_stream: %0d beats, %0d bad, timeout=%0d; required 3105 beats, 0 bad", obs_q.size(), mm, to);
        end
        checks++;
        if ({halt, done, out_valid} !== 3'b110) begin
            failures++;
            $display("FAIL retrig_final: halt/done/valid=%b required 110", {halt, done, out_valid});
        end
    endtask

    task automatic test_reset_midstream();
        int cycles;
        bit to;
        int mm;
        do_reset();
        push_expected();
        out_ready = 1'b1;
        trigger();
        cycles = 0;
        while (obs_q.size() < 39 && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
        end
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || {out_tag, out_index, out_data} !== {2'b01, 32'h1C, 32'hA000_0007}) begin
            failures++;
            $display("FAIL mid_stall: valid=%b beat=%h required valid=1 beat=%h", out_valid, {out_tag, out_index, out_data}, {2'b01, 32'h1C, 32'hA000_0007});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++;
        if ({halt, out_valid, done, out_tag, out_index, out_data} !== 69'd0 || reg_rd_addr !== 5'd0 || mem_rd_addr !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: halt=%b valid=%b done=%b beat=%h required all 0", halt, out_valid, done, {out_tag, out_index, out_data});
        end
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
        end
        mm = 0;
        for (int i = 0; i < 39; i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mm++;
        checks++;
        if (mm != 0 || obs_q.size() != 39 || halt !== 1'b0) begin
            failures++;
            $display("FAIL mid_prefix: %0d beats, %0d bad, halt=%b; required 39 beats, 0 bad, halt=0", obs_q.size(), mm, halt);
        end
        push_expected();
        trigger();
        wait_done(4000, 1'b0, cycles, to);
        mm = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mm++;
        checks++;
        if (to || mm != 0 || obs_q.size() != 3105) begin
            failures++;
            $display("FAIL mid_restart: %0d beats, %0d bad, timeout=%0d; required 3105 beats, 0 bad", obs_q.size(), mm, to);
        end
    endtask

    task automatic test_held_syscall();
        int cycles;
        bit to;
        int mm;
        int low_halt;
        do_reset();
        push_expected();
        out_ready = 1'b1;
        syscall = 1'b1;
        @(posedge clock); #1;
        low_halt = 0;
        for (int i = 0; i < 49; i++) begin
            if (halt !== 1'b1) low_halt++;
            @(posedge clock); #1;
        end
        syscall = 1'b0;
        checks++;
        if (low_halt != 0) begin
            failures++;
            $display("FAIL held_halt: halt low on %0d cycles required 0", low_halt);
        end
        wait_done(4000, 1'b0, cycles, to);
        repeat (10) begin
            @(posedge clock); #1;
        end
        mm = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mm++;
        checks++;
        if (to || mm != 0 || obs_q.size() != 3105 || halt !== 1'b1) begin
            failures++;
            $display("FAIL held_stream: %0d beats, %0d bad, timeout=%0d, halt=%b; required 3105 beats, 0 bad, halt=1", obs_q.size(), mm, to, halt);
        end
        checks++;
        if (rd_viol != 0) begin
            failures++;
            $display("FAIL early_read: %0d cycles with read address while halt low, required 0", rd_viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'(i) * 32'h11;
        for (int w = 0; w < 3072; w++) mem_model[w] = 32'hA000_0000 + 32'(w);
        reset     = 1'b0;
        syscall   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_retrigger();
        test_reset_midstream();
        test_held_syscall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
